// File: rtl/st7735_init_ctrl.sv
// ST7735 power-on sequencer: pulses the panel reset, walks the init ROM over a valid/ready
// byte link and inserts the SWRESET/SLPOUT settle delays. Optional: ST7735_INIT_SKIP_NOP_EN.
module st7735_init_ctrl #(
  parameter int unsigned N                = 22,
  parameter int unsigned RST_PULSE_CYC    = 1000,
  parameter int unsigned RST_WAIT_CYC     = 6000000,
  parameter int unsigned SWRESET_WAIT_CYC = 7500000,
  parameter int unsigned SLPOUT_WAIT_CYC  = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [$clog2(N)-1:0] rom_idx,
  input  logic                 rom_is_data,
  input  logic [7:0]           rom_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_dc,
  input  logic                 tx_idle,
  output logic                 lcd_rst_n,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W    = $clog2(N);
  localparam int unsigned MAX_A    = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int unsigned MAX_B    = (SWRESET_WAIT_CYC > SLPOUT_WAIT_CYC) ? SWRESET_WAIT_CYC
                                                                          : SLPOUT_WAIT_CYC;
  localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;

  // Terminal counts; a wait of 0 is treated as a wait of 1.
  localparam logic [CNT_W-1:0] PULSE_LAST   = (RST_PULSE_CYC == 0) ? '0 : CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RWAIT_LAST   = (RST_WAIT_CYC == 0) ? '0 : CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SWRESET_LAST = (SWRESET_WAIT_CYC == 0) ? '0
                                                                      : CNT_W'(SWRESET_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SLPOUT_LAST  = (SLPOUT_WAIT_CYC == 0) ? '0
                                                                     : CNT_W'(SLPOUT_WAIT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;

  typedef enum logic [3:0] {
    IDLE, HW_RST, HW_WAIT, FETCH, SEND, DRAIN, DELAY, FINISH, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dc_q, tx_dc_d;
  logic             lcd_rst_n_q, lcd_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_last;
  logic             is_delay_cmd;
  logic [CNT_W-1:0] delay_last;

  assign is_last      = (idx_q == LAST_IDX);
  assign is_delay_cmd = !tx_dc_q && (tx_byte_q == CMD_SWRESET || tx_byte_q == CMD_SLPOUT);
  // tx_byte_q still holds the delay-triggering command while in DRAIN/DELAY.
  assign delay_last   = (tx_byte_q == CMD_SLPOUT) ? SLPOUT_LAST : SWRESET_LAST;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    tx_dc_d     = tx_dc_q;
    lcd_rst_n_d = lcd_rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = HW_RST;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          idx_d       = '0;
          lcd_rst_n_d = 1'b0;
        end
      end
      HW_RST: begin
        if (cnt_q == PULSE_LAST) begin
          state_d     = HW_WAIT;
          lcd_rst_n_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HW_WAIT: begin
        if (cnt_q == RWAIT_LAST) begin
          state_d = FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: begin
`ifdef ST7735_INIT_SKIP_NOP_EN
        if (!rom_is_data && rom_byte == 8'h00) begin
          if (is_last) state_d = FINISH;
          else         idx_d   = idx_q + IDX_W'(1);
        end else
`endif
        begin
          tx_byte_d  = rom_byte;
          tx_dc_d    = rom_is_data;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (is_delay_cmd)  state_d = DRAIN;
          else if (is_last)  state_d = FINISH;
          else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        // The settle time counts from the end of the shift, not from the handshake.
        if (tx_idle) begin
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (cnt_q == delay_last) begin
          cnt_d = '0;
          if (is_last) state_d = FINISH;
          else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        if (tx_idle) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_dc_q     <= 1'b0;
      lcd_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      tx_dc_q     <= tx_dc_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_idx   = idx_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign tx_dc     = tx_dc_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
